// File: rtl/lsu_ctrl_pkg.sv
// Shared types and constants for the load/store unit: access sizes, FSM states,
// byte-lane base masks and the alignment rule.
package lsu_ctrl_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    function automatic logic [7:0] base_mask(input lsu_size_e size);
        case (size)
            SIZE_B:  return MASK_B;
            SIZE_H:  return MASK_H;
            SIZE_W:  return MASK_W;
            default: return MASK_D;
        endcase
    endfunction

    // Natural alignment: an access must start on a multiple of its own size.
    function automatic logic is_misaligned(input lsu_size_e size, input logic [2:0] off);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return off[0] != 1'b0;
            SIZE_W:  return off[1:0] != 2'b00;
            default: return off != 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data extraction: selects the addressed bytes from an 8-byte-aligned word
// and sign- or zero-extends them to XLEN.
module lsu_load_ext
    import lsu_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      off,
    input  lsu_size_e       size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] raw;

    always_comb begin
        raw  = rdata >> {off, 3'b000};
        data = raw;
        case (size)
            SIZE_B:  data = {{(XLEN-8){raw[7] & ~is_unsigned}}, raw[7:0]};
            SIZE_H:  data = {{(XLEN-16){raw[15] & ~is_unsigned}}, raw[15:0]};
            SIZE_W:  data = {{(XLEN-32){raw[31] & ~is_unsigned}}, raw[31:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: accepts one request at a time from execute, issues a single
// aligned memory transaction and returns a writeback pulse for loads.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [RD_W-1:0] req_rd,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wmask,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            done,
    output logic            misalign
);

    lsu_state_e      state_q, state_d;
    logic            store_q, store_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [7:0]      wmask_q, wmask_d;
    lsu_size_e       size_q, size_d;
    logic            uns_q, uns_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            misalign_q, misalign_d;

    lsu_size_e       req_size_e;
    logic [2:0]      req_off;
    logic [XLEN-1:0] ext_data;

    assign req_size_e = lsu_size_e'(req_size);
    assign req_off    = req_addr[2:0];

    lsu_load_ext #(.XLEN(XLEN)) u_load_ext (
        .rdata       (mem_rdata),
        .off         (addr_q[2:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (ext_data)
    );

    always_comb begin
        state_d    = state_q;
        store_d    = store_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        size_d     = size_q;
        uns_d      = uns_q;
        rd_d       = rd_q;
        wb_data_d  = '0;
        misalign_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (is_misaligned(req_size_e, req_off)) begin
                        misalign_d = 1'b1;
                    end else begin
                        store_d = req_store;
                        addr_d  = req_addr;
                        wdata_d = req_wdata << {req_off, 3'b000};
                        wmask_d = base_mask(req_size_e) << req_off;
                        size_d  = req_size_e;
                        uns_d   = req_unsigned;
                        rd_d    = req_rd;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Read data is only valid alongside rvalid, so capture it here.
                if (mem_rvalid) begin
                    state_d = ST_RESP;
                    if (!store_q) wb_data_d = ext_data;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            store_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            size_q     <= SIZE_B;
            uns_q      <= 1'b0;
            rd_q       <= '0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            store_q    <= store_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            rd_q       <= rd_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign mem_valid = (state_q == ST_REQ);
    assign mem_we    = mem_valid & store_q;
    assign mem_addr  = {addr_q[XLEN-1:3], 3'b000};
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign wb_valid  = (state_q == ST_RESP) & ~store_q;
    assign wb_rd     = wb_valid ? rd_q : '0;
    assign wb_data   = wb_data_q;
    assign done      = (state_q == ST_RESP) | misalign_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized traffic
// compared against a byte-arithmetic reference model.
module tb_lsu_ctrl;

    typedef struct {
        logic        st;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [1:0]  size;
        logic        uns;
        logic [4:0]  rd;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_store, req_unsigned;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic [4:0]  req_rd;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        wb_valid, done, misalign;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;

    int checks = 0;
    int errors = 0;

    lsu_ctrl #(.XLEN(64), .RD_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_rd(req_rd),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .done(done), .misalign(misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    function automatic bit model_misaligned(input op_t o);
        return (int'(o.addr[2:0]) % nbytes(o.size)) != 0;
    endfunction

    function automatic logic [7:0] model_mask(input op_t o);
        int m;
        m = ((1 << nbytes(o.size)) - 1) << int'(o.addr[2:0]);
        return m[7:0];
    endfunction

    function automatic logic [63:0] model_wdata(input op_t o);
        logic [127:0] t;
        t = {64'd0, o.wdata} << (8 * int'(o.addr[2:0]));
        return t[63:0];
    endfunction

    function automatic logic [63:0] model_load(input op_t o);
        logic [127:0] v, lim;
        int n;
        n   = nbytes(o.size);
        lim = 128'd1 << (8 * n);
        v   = {64'd0, o.rdata} >> (8 * int'(o.addr[2:0]));
        v   = v & (lim - 128'd1);
        if (!o.uns && n < 8 && v[8*n-1]) v = v | ~(lim - 128'd1);
        return v[63:0];
    endfunction

    function automatic op_t mk(input logic st, input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [63:0] rdata, input logic [1:0] size, input logic uns,
                               input logic [4:0] rd);
        op_t o;
        o.st = st; o.addr = addr; o.wdata = wdata; o.rdata = rdata;
        o.size = size; o.uns = uns; o.rd = rd;
        return o;
    endfunction

    task automatic drive_req(input op_t o);
        req_valid    = 1'b1;
        req_store    = o.st;
        req_addr     = o.addr;
        req_wdata    = o.wdata;
        req_size     = o.size;
        req_unsigned = o.uns;
        req_rd       = o.rd;
    endtask

    // Runs one request through the LSU with the given memory delays, checking
    // every cycle. With no_wait the current negedge is already the IDLE cycle.
    task automatic run_op(input op_t o, input bit no_wait, input bit hold, input op_t nxt,
                          input int rdy_dly, input int rv_dly);
        logic [63:0] e_addr, e_wdata, e_wb;
        logic [7:0]  e_mask;
        e_addr  = {o.addr[63:3], 3'b000};
        e_mask  = model_mask(o);
        e_wdata = model_wdata(o);
        e_wb    = model_load(o);
        if (!no_wait) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready_idle: got %b want 1", req_ready); end
        drive_req(o);
        @(negedge clk);
        if (hold) drive_req(nxt);
        else req_valid = 1'b0;
        if (model_misaligned(o)) begin
            checks++;
            if (misalign !== 1'b1) begin errors++; $display("FAIL misalign_pulse: got %b want 1", misalign); end
            checks++;
            if (done !== 1'b1) begin errors++; $display("FAIL misalign_done: got %b want 1", done); end
            checks++;
            if (mem_valid !== 1'b0) begin errors++; $display("FAIL misalign_no_mem: got %b want 0", mem_valid); end
            checks++;
            if (wb_valid !== 1'b0) begin errors++; $display("FAIL misalign_no_wb: got %b want 0", wb_valid); end
        end else begin
            checks++;
            if (misalign !== 1'b0) begin errors++; $display("FAIL misalign_spurious: got %b want 0", misalign); end
            for (int k = 0; k <= rdy_dly; k++) begin
                if (k > 0) @(negedge clk);
                checks++;
                if (mem_valid !== 1'b1) begin errors++; $display("FAIL mem_valid_req: got %b want 1 (k=%0d)", mem_valid, k); end
                checks++;
                if (mem_addr !== e_addr) begin errors++; $display("FAIL mem_addr: got %h want %h", mem_addr, e_addr); end
                checks++;
                if (mem_we !== o.st) begin errors++; $display("FAIL mem_we: got %b want %b", mem_we, o.st); end
                if (o.st) begin
                    checks++;
                    if (mem_wmask !== e_mask) begin errors++; $display("FAIL mem_wmask: got %h want %h", mem_wmask, e_mask); end
                    checks++;
                    if (mem_wdata !== e_wdata) begin errors++; $display("FAIL mem_wdata: got %h want %h", mem_wdata, e_wdata); end
                end
                checks++;
                if (req_ready !== 1'b0 || done !== 1'b0) begin
                    errors++; $display("FAIL busy_req: ready=%b done=%b want 0 0", req_ready, done);
                end
                if (k == rdy_dly) mem_ready = 1'b1;
            end
            for (int j = 0; j <= rv_dly; j++) begin
                @(negedge clk);
                if (j == 0) mem_ready = 1'b0;
                checks++;
                if (mem_valid !== 1'b0 || req_ready !== 1'b0 || done !== 1'b0) begin
                    errors++; $display("FAIL wait_state: valid=%b ready=%b done=%b want 0 0 0", mem_valid, req_ready, done);
                end
                if (j == rv_dly) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = o.rdata;
                end
            end
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = {$urandom, $urandom};
            checks++;
            if (done !== 1'b1) begin errors++; $display("FAIL done_pulse: got %b want 1", done); end
            checks++;
            if (wb_valid !== !o.st) begin errors++; $display("FAIL wb_valid: got %b want %b", wb_valid, !o.st); end
            checks++;
            if (req_ready !== 1'b0) begin errors++; $display("FAIL resp_ready: got %b want 0", req_ready); end
            if (!o.st) begin
                checks++;
                if (wb_rd !== o.rd) begin errors++; $display("FAIL wb_rd: got %0d want %0d", wb_rd, o.rd); end
                checks++;
                if (wb_data !== e_wb) begin errors++; $display("FAIL wb_data: got %h want %h", wb_data, e_wb); end
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || wb_valid !== 1'b0 || req_ready !== 1'b1 || mem_valid !== 1'b0) begin
                errors++;
                $display("FAIL after_resp: done=%b wb=%b ready=%b mvalid=%b want 0 0 1 0", done, wb_valid, req_ready, mem_valid);
            end
        end
    endtask

    op_t none;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        checks++;
        if ({mem_valid, mem_we, wb_valid, done, misalign} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000", {mem_valid, mem_we, wb_valid, done, misalign});
        end
        checks++;
        if (mem_addr !== 64'd0 || mem_wdata !== 64'd0 || mem_wmask !== 8'd0 || wb_data !== 64'd0 || wb_rd !== 5'd0) begin
            errors++; $display("FAIL reset_data: addr=%h wdata=%h mask=%h wb=%h rd=%0d want all 0",
                               mem_addr, mem_wdata, mem_wmask, wb_data, wb_rd);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_store_d();
        run_op(mk(1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 64'hdead_beef_0000_0001, 2'd3, 1'b0, 5'd3),
               1'b0, 1'b0, none, 0, 0);
    endtask

    task automatic test_store_b();
        run_op(mk(1'b1, 64'h8000_0005, 64'h0000_0000_0000_00AB, 64'd0, 2'd0, 1'b0, 5'd1),
               1'b0, 1'b0, none, 0, 0);
    endtask

    task automatic test_load_ext();
        run_op(mk(1'b0, 64'h8000_0004, 64'd0, 64'h8000_0000_0000_0000, 2'd2, 1'b0, 5'd7), 1'b0, 1'b0, none, 0, 0);
        run_op(mk(1'b0, 64'h8000_0004, 64'd0, 64'h8000_0000_0000_0000, 2'd2, 1'b1, 5'd7), 1'b0, 1'b0, none, 0, 0);
        run_op(mk(1'b0, 64'h8000_0006, 64'd0, 64'h80F0_1234_5678_9ABC, 2'd1, 1'b0, 5'd0), 1'b0, 1'b0, none, 0, 0);
        run_op(mk(1'b0, 64'h8000_0000, 64'd0, 64'hFEDC_BA98_7654_3210, 2'd3, 1'b1, 5'd31), 1'b0, 1'b0, none, 0, 0);
    endtask

    task automatic test_misalign();
        run_op(mk(1'b0, 64'h8000_0003, 64'd0, 64'd0, 2'd1, 1'b0, 5'd4), 1'b0, 1'b0, none, 0, 0);
        run_op(mk(1'b0, 64'h8000_0010, 64'd0, 64'h0123_4567_89AB_CDEF, 2'd3, 1'b0, 5'd5), 1'b1, 1'b0, none, 0, 0);
    endtask

    task automatic test_back_to_back();
        op_t a, b;
        a = mk(1'b1, 64'h8000_0012, 64'h0000_0000_0000_BEEF, 64'd0, 2'd1, 1'b0, 5'd2);
        b = mk(1'b0, 64'h8000_0021, 64'd0, {$urandom, $urandom}, 2'd0, 1'b0, 5'd9);
        run_op(a, 1'b0, 1'b1, b, 4, 3);
        run_op(b, 1'b1, 1'b0, none, 0, 0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive_req(mk(1'b0, 64'h8000_0018, 64'd0, 64'd0, 2'd3, 1'b0, 5'd6));
        @(negedge clk);
        req_valid = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || {mem_valid, mem_we, wb_valid, done, misalign} !== 5'b0) begin
            errors++; $display("FAIL midreset_ctrl: ready=%b ctrl=%b want 1 00000", req_ready,
                               {mem_valid, mem_we, wb_valid, done, misalign});
        end
        checks++;
        if (mem_addr !== 64'd0 || mem_wdata !== 64'd0 || mem_wmask !== 8'd0 || wb_data !== 64'd0) begin
            errors++; $display("FAIL midreset_data: addr=%h wdata=%h mask=%h wb=%h want all 0",
                               mem_addr, mem_wdata, mem_wmask, wb_data);
        end
        @(negedge clk);
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (done !== 1'b0 || wb_valid !== 1'b0) begin
                errors++; $display("FAIL midreset_no_pulse: done=%b wb=%b want 0 0", done, wb_valid);
            end
            @(negedge clk);
        end
        run_op(mk(1'b0, 64'h8000_0040, 64'd0, 64'hA5A5_5A5A_0F0F_F0F0, 2'd3, 1'b0, 5'd11), 1'b1, 1'b0, none, 0, 0);
    endtask

    task automatic test_random();
        op_t o;
        int n;
        for (int i = 0; i < 40; i++) begin
            o.st   = 1'($urandom_range(0, 1));
            o.size = 2'($urandom_range(0, 3));
            o.addr = {32'h8000_0000, $urandom};
            n      = nbytes(o.size);
            if ($urandom_range(0, 3) != 0) o.addr[2:0] = 3'((int'(o.addr[2:0]) / n) * n);
            o.wdata = {$urandom, $urandom};
            o.rdata = {$urandom, $urandom};
            o.uns   = 1'($urandom_range(0, 1));
            o.rd    = 5'($urandom_range(0, 31));
            run_op(o, 1'($urandom_range(0, 1)), 1'b0, none, $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        none = mk(1'b0, 64'd0, 64'd0, 64'd0, 2'd0, 1'b0, 5'd0);
        req_valid = 1'b0; req_store = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'd0; req_unsigned = 1'b0; req_rd = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        test_reset();
        test_store_d();
        test_store_b();
        test_load_ext();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
